// File: rtl/mos6502_decode_stage.sv
// Opcode decode stage: buffers fetched 6502 opcode bytes in a small FIFO and
// registers addressing mode / operand length / undocumented flag for the sequencer.
module mos6502_decode_stage #(
    parameter int DEPTH        = 4,
    parameter bit PASS_ILLEGAL = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     clr_err_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [7:0]               opcode_i,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [7:0]               dec_opcode_o,
    output logic [3:0]               dec_mode_o,
    output logic [1:0]               dec_len_o,
    output logic                     dec_illegal_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     illegal_seen_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [AW:0] ONE  = 1;

    localparam logic [3:0] M_IMPL = 4'd0,  M_ACC  = 4'd1,  M_IMM  = 4'd2,
                           M_ZPG  = 4'd3,  M_ZPGX = 4'd4,  M_ZPGY = 4'd5,
                           M_ABS  = 4'd6,  M_ABSX = 4'd7,  M_ABSY = 4'd8,
                           M_IND  = 4'd9,  M_XIND = 4'd10, M_INDY = 4'd11,
                           M_REL  = 4'd12;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_dvalid, r_dill, r_seen;
    logic [7:0]    r_dop;
    logic [3:0]    r_dmode;
    logic [1:0]    r_dlen;

    logic [7:0] w_head;
    logic [2:0] w_aaa, w_bbb;
    logic [1:0] w_cc;
    logic [3:0] w_mode;
    logic [1:0] w_len;
    logic       w_ill, w_push, w_pop, w_load;

    assign w_head = r_mem[r_rptr];
    assign w_aaa  = w_head[7:5];
    assign w_bbb  = w_head[4:2];
    assign w_cc   = w_head[1:0];

    // Decode follows the aaa/bbb/cc layout of the NMOS opcode matrix;
    // undocumented cells keep the impl/len-0 defaults and raise w_ill.
    always_comb begin
        w_mode = M_IMPL;
        w_ill  = 1'b0;
        case (w_cc)
            2'b01: case (w_bbb)
                3'b000: w_mode = M_XIND;
                3'b001: w_mode = M_ZPG;
                3'b010: if (w_aaa == 3'd4) w_ill = 1'b1; else w_mode = M_IMM;
                3'b011: w_mode = M_ABS;
                3'b100: w_mode = M_INDY;
                3'b101: w_mode = M_ZPGX;
                3'b110: w_mode = M_ABSY;
                default: w_mode = M_ABSX;
            endcase
            2'b10: case (w_bbb)
                3'b000: if (w_aaa == 3'd5) w_mode = M_IMM; else w_ill = 1'b1;
                3'b001: w_mode = M_ZPG;
                3'b010: w_mode = w_aaa[2] ? M_IMPL : M_ACC;
                3'b011: w_mode = M_ABS;
                3'b100: w_ill = 1'b1;
                3'b101: w_mode = (w_aaa == 3'd4 || w_aaa == 3'd5) ? M_ZPGY : M_ZPGX;
                3'b110: if (w_aaa != 3'd4 && w_aaa != 3'd5) w_ill = 1'b1;
                default: begin
                    if (w_aaa == 3'd4)      w_ill  = 1'b1;
                    else if (w_aaa == 3'd5) w_mode = M_ABSY;
                    else                    w_mode = M_ABSX;
                end
            endcase
            2'b00: case (w_bbb)
                3'b000: begin
                    if (w_aaa == 3'd1)      w_mode = M_ABS;
                    else if (w_aaa == 3'd4) w_ill  = 1'b1;
                    else if (w_aaa[2])      w_mode = M_IMM;
                end
                3'b001: if (w_aaa == 3'd0 || w_aaa == 3'd2 || w_aaa == 3'd3) w_ill = 1'b1;
                        else w_mode = M_ZPG;
                3'b010: w_mode = M_IMPL;
                3'b011: begin
                    if (w_aaa == 3'd0)      w_ill  = 1'b1;
                    else if (w_aaa == 3'd3) w_mode = M_IND;
                    else                    w_mode = M_ABS;
                end
                3'b100: w_mode = M_REL;
                3'b101: if (w_aaa == 3'd4 || w_aaa == 3'd5) w_mode = M_ZPGX; else w_ill = 1'b1;
                3'b110: w_mode = M_IMPL;
                default: if (w_aaa == 3'd5) w_mode = M_ABSX; else w_ill = 1'b1;
            endcase
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (w_mode)
            M_IMPL, M_ACC:                  w_len = 2'd0;
            M_ABS, M_ABSX, M_ABSY, M_IND:   w_len = 2'd2;
            default:                        w_len = 2'd1;
        endcase
    end

    assign fetch_ready_o = (r_level != FULL);
    assign w_push = fetch_valid_i && fetch_ready_o;
    assign w_pop  = (r_level != '0) && (!r_dvalid || dec_ready_i);
    assign w_load = w_pop && (PASS_ILLEGAL || !w_ill);

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= opcode_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_dvalid <= 1'b0;
            r_dop    <= 8'h00;
            r_dmode  <= 4'd0;
            r_dlen   <= 2'd0;
            r_dill   <= 1'b0;
        end else if (flush_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_dvalid <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + ONE;
            else if (!w_push && w_pop) r_level <= r_level - ONE;
            if (w_load) begin
                r_dvalid <= 1'b1;
                r_dop    <= w_head;
                r_dmode  <= w_mode;
                r_dlen   <= w_len;
                r_dill   <= w_ill;
            end else if (w_pop || dec_ready_i) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    // A discarded (flushed) head never sets the sticky flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                           r_seen <= 1'b0;
        else if (w_pop && w_ill && !flush_i)   r_seen <= 1'b1;
        else if (clr_err_i)                    r_seen <= 1'b0;
    end

    assign dec_valid_o    = r_dvalid;
    assign dec_opcode_o   = r_dop;
    assign dec_mode_o     = r_dmode;
    assign dec_len_o      = r_dlen;
    assign dec_illegal_o  = r_dill;
    assign level_o        = r_level;
    assign illegal_seen_o = r_seen;
endmodule
